// File: rtl/hazard_scoreboard.sv
// Per-register readiness scoreboard for the ID stage: stalls, bubbles and fetch flushes.
// Optional stall performance counter enabled by defining HAZ_PERF_CNT_EN.
module hazard_scoreboard #(
    parameter int REG_AW       = 5,
    parameter int LOAD_LAT     = 1,
    parameter int BRANCH_IN_ID = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_is_branch,
    input  logic              id_wr_en,
    input  logic [REG_AW-1:0] id_wr_rd,
    input  logic              id_is_load,
    input  logic              br_taken,
    input  logic              jump,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              idex_flush,
    output logic              if_flush
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);

    localparam int NREG = 1 << REG_AW;
    localparam int CW   = $clog2(LOAD_LAT + 2);

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t LOAD_SET = cnt_t'(LOAD_LAT + 1);
    localparam cnt_t ALU_SET  = cnt_t'(1);

    cnt_t cnt_q [NREG];
    cnt_t cnt_d [NREG];

    logic stall;
    logic issue;
    cnt_t need;
    logic rs_blocked;
    logic rt_blocked;

    // A branch compared in ID needs its operands one cycle earlier than an EX consumer.
    always_comb begin
        need       = (id_is_branch && (BRANCH_IN_ID != 0)) ? '0 : cnt_t'(1);
        rs_blocked = id_use_rs && (id_rs != '0) && (cnt_q[id_rs] > need);
        rt_blocked = id_use_rt && (id_rt != '0) && (cnt_q[id_rt] > need);
        stall      = id_valid && (rs_blocked || rt_blocked);
        issue      = id_valid && !stall;
    end

    // NOTE: every cnt_d entry gets a default before the conditional override, so no latch is inferred.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - cnt_t'(1) : '0;
        end
        if (issue && id_wr_en && (id_wr_rd != '0)) begin
            cnt_d[id_wr_rd] = id_is_load ? LOAD_SET : ALU_SET;
        end
        cnt_d[0] = '0;
    end

    // NOTE: the scoreboard is reset in full; stale counts after reset would cause phantom stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            // NOTE: non-blocking so every counter updates from the same pre-edge snapshot.
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    always_comb begin
        pc_write   = !stall;
        ifid_write = !stall;
        idex_flush = stall;
        if_flush   = issue && ((id_is_branch && br_taken) || jump);
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: three scoreboards (default, LOAD_LAT=3, BRANCH_IN_ID=0) share one stimulus stream.
module tb_hazard_scoreboard;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       id_is_branch;
    logic       id_wr_en;
    logic [4:0] id_wr_rd;
    logic       id_is_load;
    logic       br_taken;
    logic       jump;

    logic [2:0]  pc_w;
    logic [2:0]  ifid_w;
    logic [2:0]  idex_f;
    logic [2:0]  if_f;
    logic [31:0] sc0, sc1, sc2;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_scoreboard #(.REG_AW(5), .LOAD_LAT(1), .BRANCH_IN_ID(1)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_is_branch(id_is_branch),
        .id_wr_en(id_wr_en), .id_wr_rd(id_wr_rd), .id_is_load(id_is_load),
        .br_taken(br_taken), .jump(jump), .pc_write(pc_w[0]), .ifid_write(ifid_w[0]),
        .idex_flush(idex_f[0]), .if_flush(if_f[0])
`ifdef HAZ_PERF_CNT_EN
        , .stall_cycles(sc0)
`endif
    );

    hazard_scoreboard #(.REG_AW(5), .LOAD_LAT(3), .BRANCH_IN_ID(1)) dut_l3 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_is_branch(id_is_branch),
        .id_wr_en(id_wr_en), .id_wr_rd(id_wr_rd), .id_is_load(id_is_load),
        .br_taken(br_taken), .jump(jump), .pc_write(pc_w[1]), .ifid_write(ifid_w[1]),
        .idex_flush(idex_f[1]), .if_flush(if_f[1])
`ifdef HAZ_PERF_CNT_EN
        , .stall_cycles(sc1)
`endif
    );

    hazard_scoreboard #(.REG_AW(5), .LOAD_LAT(1), .BRANCH_IN_ID(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_is_branch(id_is_branch),
        .id_wr_en(id_wr_en), .id_wr_rd(id_wr_rd), .id_is_load(id_is_load),
        .br_taken(br_taken), .jump(jump), .pc_write(pc_w[2]), .ifid_write(ifid_w[2]),
        .idex_flush(idex_f[2]), .if_flush(if_f[2])
`ifdef HAZ_PERF_CNT_EN
        , .stall_cycles(sc2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_instr(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                             input logic urt, input logic br, input logic wr,
                             input logic [4:0] rd, input logic ld);
        id_valid = 1'b1; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_is_branch = br; id_wr_en = wr; id_wr_rd = rd; id_is_load = ld;
    endtask

    task automatic i_lw(input logic [4:0] rd, input logic [4:0] base);
        set_instr(base, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, rd, 1'b1);
    endtask

    task automatic i_add(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
        set_instr(a, b, 1'b1, 1'b1, 1'b0, 1'b1, rd, 1'b0);
    endtask

    task automatic i_beq(input logic [4:0] a, input logic [4:0] b);
        set_instr(a, b, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic i_nop();
        set_instr(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic bubble(input int n);
        id_valid = 1'b0; id_use_rs = 1'b0; id_use_rt = 1'b0; id_wr_en = 1'b0;
        id_is_branch = 1'b0; br_taken = 1'b0; jump = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds the current instruction in ID until instance sel accepts it.
    task automatic run_instr(input int sel, output int stalls, output int fl_stall,
                             output logic fl_issue);
        logic done;
        stalls = 0; fl_stall = 0; fl_issue = 1'b0; done = 1'b0;
        for (int i = 0; i < 12 && !done; i++) begin
            @(negedge clk);
            if (!idex_f[sel]) begin
                fl_issue = if_f[sel];
                check("pc_write_at_issue", 32'(pc_w[sel]), 32'd1);
                done = 1'b1;
            end else begin
                stalls++;
                fl_stall += int'(if_f[sel]);
                check("ifid_write_in_stall", 32'(ifid_w[sel]), 32'd0);
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("issue_timeout", 32'd0, 32'd1);
    endtask

    task automatic issue(input int sel, input string tag, input int exp_stalls);
        int   s, fs;
        logic fi;
        run_instr(sel, s, fs, fi);
        check(tag, 32'(s), 32'(exp_stalls));
    endtask

    initial begin
        int   s, fs;
        logic fi;
        rst_n = 1'b0;
        bubble(0);
        id_rs = '0; id_rt = '0; id_wr_rd = '0; id_is_load = 1'b0;
        #12;
        check("rst_pc_write", 32'(pc_w), 32'd7);
        check("rst_ifid_write", 32'(ifid_w), 32'd7);
        check("rst_idex_flush", 32'(idex_f), 32'd0);
        check("rst_if_flush", 32'(if_f), 32'd0);
`ifdef HAZ_PERF_CNT_EN
        check("rst_stall_cycles", sc0, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        i_lw(5'd8, 5'd0);        issue(0, "lw_issue", 0);
        i_add(5'd10, 5'd8, 5'd9); issue(0, "lw_add", 1);
        bubble(3);
        i_add(5'd8, 5'd1, 5'd2); issue(0, "alu_issue", 0);
        i_beq(5'd8, 5'd9);       issue(0, "alu_beq", 1);
        bubble(3);
        i_lw(5'd8, 5'd0);        issue(0, "lw_issue2", 0);
        i_beq(5'd8, 5'd0); br_taken = 1'b1;
        run_instr(0, s, fs, fi);
        check("lw_beq", 32'(s), 32'd2);
        check("beq_flush_in_stall", 32'(fs), 32'd0);
        check("beq_flush_at_issue", 32'(fi), 32'd1);
`ifdef HAZ_PERF_CNT_EN
        check("perf_stall_cycles", sc0, 32'd4);
`endif
        bubble(3);

        i_lw(5'd8, 5'd0);        issue(0, "lw_issue3", 0);
        i_nop();                 issue(0, "nop_issue", 0);
        i_beq(5'd8, 5'd0);       issue(0, "lw_nop_beq", 1);
        bubble(3);

        i_add(5'd8, 5'd1, 5'd2); issue(2, "nb_alu_issue", 0);
        i_beq(5'd8, 5'd9);       issue(2, "nb_alu_beq", 0);
        bubble(3);

        i_add(5'd8, 5'd1, 5'd2); issue(0, "alu_issue2", 0);
        set_instr(5'd8, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
        issue(0, "unused_src_no_stall", 0);
        bubble(6);

        i_lw(5'd8, 5'd0);        issue(1, "l3_lw_issue", 0);
        i_add(5'd10, 5'd8, 5'd8); issue(1, "l3_lw_add_rs_eq_rt", 3);
        bubble(6);
        i_lw(5'd0, 5'd1);        issue(1, "l3_lw_r0", 0);
        i_add(5'd10, 5'd0, 5'd0); issue(1, "l3_use_r0", 0);
        bubble(6);

        i_lw(5'd8, 5'd8);        issue(0, "self_lw", 0);
        i_add(5'd9, 5'd8, 5'd0); issue(0, "self_lw_use", 1);
        bubble(3);

        i_nop(); jump = 1'b1;
        @(negedge clk);
        check("jump_if_flush", 32'(if_f[0]), 32'd1);
        check("jump_no_stall", 32'(idex_f[0]), 32'd0);
        id_valid = 1'b0;
        #1;
        check("jump_invalid_no_flush", 32'(if_f[0]), 32'd0);
        bubble(2);

        i_lw(5'd8, 5'd0);        issue(0, "lw_issue4", 0);
        i_add(5'd9, 5'd8, 5'd0);
        @(negedge clk);
        check("pre_rst_stall", 32'(idex_f[0]), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_pc_write", 32'(pc_w[0]), 32'd1);
        check("mid_rst_idex_flush", 32'(idex_f[0]), 32'd0);
`ifdef HAZ_PERF_CNT_EN
        check("mid_rst_stall_cycles", sc0, 32'd0);
`endif
        #1 rst_n = 1'b1;
        issue(0, "post_rst_add", 0);
        bubble(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised successor to the pipeline's combinational load-use hazard detector. Keeps a per-register readiness scoreboard with countdown counters, so it covers three cases: multi-cycle load latency, branches resolved in ID (ALU→branch and load→branch, including the 2-deep case), and taken-branch/jump fetch flush. Sits beside the ID stage and drives the PC write enable, IF/ID write enable, ID/EX bubble flush and IF/ID flush.

Parameters:
REG_AW, 5, register address width; tracked registers = 2**REG_AW; register 0 is never tracked.
LOAD_LAT, 1, cycles after EX before load data can be forwarded to an EX consumer; legal range 1..6.
BRANCH_IN_ID, 1, 1 = branch operands consumed in ID (one extra cycle of need); 0 = branch consumers are treated as EX consumers.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  IF/ID holds a live instruction
id_rs  in  REG_AW  IF/ID rs field
id_rt  in  REG_AW  IF/ID rt field
id_use_rs  in  1  instruction reads rs
id_use_rt  in  1  instruction reads rt
id_is_branch  in  1  beq/bne compared in ID
id_wr_en  in  1  instruction writes a register
id_wr_rd  in  REG_AW  destination register (rd or rt, already muxed)
id_is_load  in  1  instruction is lw
br_taken  in  1  ID branch comparator says taken
jump  in  1  ID instruction is j/jal
pc_write  out  1  PC write enable
ifid_write  out  1  IF/ID write enable
idex_flush  out  1  zero ID/EX control (bubble)
if_flush  out  1  squash the instruction entering IF/ID
stall_cycles  out  32  only with HAZ_PERF_CNT_EN; see Optional Feature

Behaviour:
- State: cnt[r], width clog2(LOAD_LAT+2), one per register r=1..2**REG_AW-1. cnt[0] is hard-wired 0.
- Issue = id_valid & ~stall. On issue with id_wr_en & id_wr_rd!=0: cnt[id_wr_rd] <= (id_is_load ? LOAD_LAT : 0) + 1.
- Every other nonzero cnt decrements by 1 each clock, saturating at 0. This includes stall cycles. A set on the same edge overrides the decrement for that register.
- need(src) = id_is_branch & BRANCH_IN_ID ? 0 : 1. A source is blocked when it is used, src!=0, and cnt[src] > need.
- stall = id_valid & (rs blocked | rt blocked). Combinational from registered cnt and ID inputs.
- pc_write = ~stall; ifid_write = ~stall; idex_flush = stall.
- if_flush = id_valid & ~stall & ((id_is_branch & br_taken) | jump). It is never asserted during a stall, because the comparator operands are not yet valid.
- Resulting penalties with LOAD_LAT=1:
  - ALU→EX consumer: 0 stalls.
  - load→EX consumer: 1 stall.
  - ALU→branch: 1 stall.
  - load→branch, adjacent: 2 stalls.
  - load→branch, one instruction between: 1 stall.
- Worst-case consecutive stall cycles = LOAD_LAT+1.
- id_valid=0 (bubble or flushed slot): no stall, no issue, counters still decay.
- rs==rt: a single blocked source stalls once; there is no double counting.
- Producer and consumer with the same register, e.g. lw $t0,0($t0) followed by use of $t0: the consumer sees its own write only after issue, so there is no self-stall.
- Reset (async, any cycle, including mid-stall): all cnt=0. Outputs settle to pc_write=1, ifid_write=1, idex_flush=0, if_flush=0 (with id_valid=0), stall_cycles=0. The first cycle after reset release never stalls.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined: adds port stall_cycles, a 32-bit counter that increments on every clock where stall=1, saturates at 32'hFFFF_FFFF, and is cleared by rst_n.
- Undefined: the port and the counter do not exist; stall behaviour is identical.

Test Plan:
- Reset with LOAD_LAT=1: pulse rst_n low mid-stall after a lw $8 issue → outputs immediately pc_write=1, idex_flush=0; next add $9,$8 issues with 0 stalls.
- lw $8 then add $10,$8,$9 → exactly 1 cycle of pc_write=0/ifid_write=0/idex_flush=1, then issue.
- add $8 then beq $8,$9 (BRANCH_IN_ID=1) → 1 stall; rebuild with BRANCH_IN_ID=0 → 0 stalls.
- lw $8 then beq $8,$0 → 2 stalls. lw $8, nop, beq $8,$0 → 1 stall. br_taken=1 → if_flush=1 only in the non-stalled cycle.
- LOAD_LAT=3: lw $8 then add $10,$8,$8 → 3 stall cycles. Write to $0 then use $0 → 0 stalls.
- HAZ_PERF_CNT_EN defined, LOAD_LAT=1: run lw→add, add→beq, lw→beq → stall_cycles=4. j with id_valid=1 → if_flush=1, no stall.
